// File: rtl/atm_disp_pkg.sv
// atm_disp_pkg: shared types and constants for the cash dispenser.
// Holds the FSM state enum, completion status codes and note values.
package atm_disp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAN,
      S_CHECK,
      S_FEED,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_NOFUNDS = 2'd1,
      ST_JAM     = 2'd2
   } status_t;

   // Note value per cassette index: 0=1, 1=5, 2=10, 3=20.
   localparam logic [3:0][5:0] DENOM = {6'd20, 6'd10, 6'd5, 6'd1};

endpackage

// File: rtl/atm_cash_dispenser_if.sv
// atm_cash_dispenser_if: request, note-feed and completion signals.
// slave = dispenser side, master = controller/transport side.
interface atm_cash_dispenser_if;

   logic       req_valid;
   logic [5:0] req_amount;
   logic       req_ready;
   logic       feed_valid;
   logic [1:0] feed_sel;
   logic       feed_ack;
   logic       done;
   logic [1:0] status;
   logic [5:0] dispensed_amt;

   modport slave (
      input  req_valid, req_amount, feed_ack,
      output req_ready, feed_valid, feed_sel,
      output done, status, dispensed_amt
   );

   modport master (
      output req_valid, req_amount, feed_ack,
      input  req_ready, feed_valid, feed_sel,
      input  done, status, dispensed_amt
   );

endinterface

// File: rtl/disp_plan_step.sv
// disp_plan_step: one greedy planning step for a single cassette.
// in: remaining, idx, cnt; out: need=min(remaining/denom,cnt), rem_next.
module disp_plan_step
   import atm_disp_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic [5:0]       remaining,
   input  logic [1:0]       idx,
   input  logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] need,
   output logic [5:0]       rem_next
);

   logic [5:0] quot;
   logic [5:0] take;
   logic       q_lt;

   always_comb begin
      unique case (idx)
         2'd3:    quot = remaining / 6'd20;
         2'd2:    quot = remaining / 6'd10;
         2'd1:    quot = remaining / 6'd5;
         default: quot = remaining;
      endcase
      q_lt = {{CNT_W{1'b0}}, quot} < {6'd0, cnt};
      need = q_lt ? CNT_W'(quot) : cnt;
      // When cnt wins it is <= quot, so it fits in 6 bits.
      take = q_lt ? quot : 6'(cnt);
      rem_next = remaining - take * DENOM[idx];
   end

endmodule

// File: rtl/atm_cash_dispenser.sv
// atm_cash_dispenser: greedy note planner and one-at-a-time feeder.
// Ports: clk, rst (sync active-low), bus (req/feed/done), load_*,
// jam, cass_cnt, audit_total (counts only with ATM_DISP_AUDIT_EN).
module atm_cash_dispenser
   import atm_disp_pkg::*;
#(
   parameter int CNT_W   = 6,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   atm_cash_dispenser_if.slave  bus,
   input  logic                 load_en,
   input  logic [1:0]           load_sel,
   input  logic [CNT_W-1:0]     load_cnt,
   output logic                 jam,
   output logic [4*CNT_W-1:0]   cass_cnt,
   output logic [15:0]          audit_total
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t                state, state_n;
   status_t               status_q, status_n;
   logic [1:0]            idx, serve;
   logic [5:0]            remaining, step_rem, disp_q;
   logic [3:0][CNT_W-1:0] cass, need_q, need_dec;
   logic [CNT_W-1:0]      step_need;
   logic [TW-1:0]         tcnt;
   logic                  jam_q, jam_set, accept, fire;

   assign accept = bus.req_valid && bus.req_ready;
   assign fire   = (state == S_FEED) && bus.feed_ack;

   assign bus.req_ready     = (state == S_IDLE) && !jam_q;
   assign bus.feed_valid    = (state == S_FEED);
   assign bus.feed_sel      = (state == S_FEED) ? serve : 2'd0;
   assign bus.done          = (state == S_DONE);
   assign bus.status        = status_q;
   assign bus.dispensed_amt = disp_q;
   assign jam               = jam_q;
   assign cass_cnt          = cass;

   // need_q doubles as the count snapshot during PLAN, so a load
   // accepted together with the request does not affect the plan.
   disp_plan_step #(.CNT_W(CNT_W)) u_step (
      .remaining (remaining),
      .idx       (idx),
      .cnt       (need_q[idx]),
      .need      (step_need),
      .rem_next  (step_rem)
   );

   always_comb begin
      state_n  = state;
      status_n = status_q;
      jam_set  = 1'b0;
      serve    = 2'd0;
      for (int i = 0; i < 4; i++)
         if (need_q[i] != '0) serve = 2'(i);
      need_dec = need_q;
      if (fire) need_dec[serve] = need_q[serve] - CNT_W'(1);
      unique case (state)
         S_IDLE: if (accept) state_n = S_PLAN;
         S_PLAN: if (idx == 2'd0) state_n = S_CHECK;
         S_CHECK: begin
            if (remaining != '0) begin
               state_n  = S_DONE;
               status_n = ST_NOFUNDS;
            end else if (need_q == '0) begin
               state_n  = S_DONE;
               status_n = ST_OK;
            end else begin
               state_n = S_FEED;
            end
         end
         S_FEED: begin
            if (fire && need_dec == '0) begin
               state_n  = S_DONE;
               status_n = ST_OK;
            end else if (!fire && tcnt == TW'(TIMEOUT - 1)) begin
               state_n  = S_DONE;
               status_n = ST_JAM;
               jam_set  = 1'b1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         status_q  <= ST_OK;
         idx       <= 2'd0;
         remaining <= '0;
         need_q    <= '0;
         cass      <= '0;
         tcnt      <= '0;
         disp_q    <= '0;
         jam_q     <= 1'b0;
      end else begin
         state    <= state_n;
         status_q <= status_n;
         if (jam_set) jam_q <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (load_en) cass[load_sel] <= load_cnt;
               if (accept) begin
                  remaining <= bus.req_amount;
                  idx       <= 2'd3;
                  need_q    <= cass;
                  disp_q    <= '0;
               end
            end
            S_PLAN: begin
               need_q[idx] <= step_need;
               remaining   <= step_rem;
               idx         <= idx - 2'd1;
            end
            // Counter holds cycles since FEED entry or the last ack.
            S_CHECK: tcnt <= TW'(1);
            S_FEED: begin
               need_q <= need_dec;
               if (fire) begin
                  cass[serve] <= cass[serve] - CNT_W'(1);
                  disp_q      <= disp_q + DENOM[serve];
                  tcnt        <= TW'(1);
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ATM_DISP_AUDIT_EN
   logic [15:0] audit_q;
   logic [16:0] audit_sum;

   assign audit_sum = {1'b0, audit_q} + {11'd0, DENOM[serve]};

   always_ff @(posedge clk) begin
      if (!rst)
         audit_q <= '0;
      else if (fire)
         audit_q <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
   end

   assign audit_total = audit_q;
`else
   assign audit_total = 16'd0;
`endif

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// tb_atm_cash_dispenser: table vectors, corner sequences and random
// withdrawals checked against a greedy reference model.
module tb_atm_cash_dispenser;
   import atm_disp_pkg::*;

   localparam int CNT_W   = 6;
   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               load_en;
   logic [1:0]         load_sel;
   logic [CNT_W-1:0]   load_cnt;
   logic               jam;
   logic [4*CNT_W-1:0] cass_cnt;
   logic [15:0]        audit_total;

   atm_cash_dispenser_if bus();

   atm_cash_dispenser #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .load_en     (load_en),
      .load_sel    (load_sel),
      .load_cnt    (load_cnt),
      .jam         (jam),
      .cass_cnt    (cass_cnt),
      .audit_total (audit_total)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] cnt;
      int          amt;
      int          st;
      int          dsp;
      int          lat;
      logic [23:0] ecnt;
   } vec_t;

   vec_t tbl [6];
   int   vecs = 0;
   int   errs = 0;
   int   mcnt [4];
   int   maudit;
   int   exp_q [$];
   int   got_q [$];

   task automatic check(input string nm, input int got, input int exp);
      vecs++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int den(input int i);
      case (i)
         3: return 20;
         2: return 10;
         1: return 5;
         default: return 1;
      endcase
   endfunction

   function automatic logic [23:0] mpack();
      return {6'(mcnt[3]), 6'(mcnt[2]), 6'(mcnt[1]), 6'(mcnt[0])};
   endfunction

   function automatic int exp_audit();
`ifdef ATM_DISP_AUDIT_EN
      return (maudit > 65535) ? 65535 : maudit;
`else
      return 0;
`endif
   endfunction

   // Greedy plan from the highest note down; updates model counts.
   function automatic void model(input int amt, output int st,
                                 output int sum);
      int rem;
      int n [4];
      rem = amt;
      sum = 0;
      exp_q.delete();
      for (int i = 3; i >= 0; i--) begin
         n[i] = rem / den(i);
         if (n[i] > mcnt[i]) n[i] = mcnt[i];
         rem = rem - n[i] * den(i);
      end
      if (rem != 0) begin
         st = 1;
         return;
      end
      st = 0;
      for (int i = 3; i >= 0; i--) begin
         for (int k = 0; k < n[i]; k++) begin
            exp_q.push_back(i);
            sum = sum + den(i);
         end
         mcnt[i] = mcnt[i] - n[i];
      end
      maudit = maudit + sum;
   endfunction

   task automatic load_all(input logic [23:0] c);
      for (int i = 0; i < 4; i++) begin
         load_en  = 1'b1;
         load_sel = 2'(i);
         load_cnt = c[i*6 +: 6];
         mcnt[i]  = int'(c[i*6 +: 6]);
         tick();
      end
      load_en = 1'b0;
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, ".cass"},  int'(cass_cnt), 0);
      check({nm, ".jam"},   int'(jam), 0);
      check({nm, ".done"},  int'(bus.done), 0);
      check({nm, ".stat"},  int'(bus.status), 0);
      check({nm, ".disp"},  int'(bus.dispensed_amt), 0);
      check({nm, ".fv"},    int'(bus.feed_valid), 0);
      check({nm, ".fsel"},  int'(bus.feed_sel), 0);
      check({nm, ".audit"}, int'(audit_total), 0);
   endtask

   // Issues one request and acks notes after random 0..maxd waits;
   // nack < 0 acks every note, otherwise only the first nack notes.
   task automatic run_txn(input int amt, input int maxd, input int nack,
                          input bit gate, output int lat, output int st,
                          output int dsp, output int sumd);
      int d, w, acks;
      got_q.delete();
      lat  = -1;
      st   = -1;
      dsp  = -1;
      sumd = 0;
      acks = 0;
      w    = 0;
      d    = int'($urandom_range(maxd, 0));
      bus.req_valid  = 1'b1;
      bus.req_amount = 6'(amt);
      tick();
      bus.req_valid = 1'b0;
      if (gate) begin
         load_en  = 1'b1;
         load_sel = 2'd3;
         load_cnt = 6'd9;
      end
      for (int cyc = 1; cyc <= 500; cyc++) begin
         bus.feed_ack = 1'b0;
         if (bus.done) begin
            lat = cyc;
            st  = int'(bus.status);
            dsp = int'(bus.dispensed_amt);
            break;
         end
         if (bus.feed_valid && (nack < 0 || acks < nack)) begin
            if (w >= d) begin
               bus.feed_ack = 1'b1;
               got_q.push_back(int'(bus.feed_sel));
               acks++;
               sumd = sumd + d;
               w = 0;
               d = int'($urandom_range(maxd, 0));
            end else begin
               w++;
            end
         end
         tick();
      end
      bus.feed_ack = 1'b0;
      load_en      = 1'b0;
      if (lat < 0) check("done_timeout", 0, 1);
   endtask

   task automatic txn_check(input string nm, input int amt, input int maxd,
                            input bit gate, output int lat, output int st,
                            output int dsp);
      int est, esum, sumd, elat, ok;
      model(amt, est, esum);
      run_txn(amt, maxd, -1, gate, lat, st, dsp, sumd);
      elat = (exp_q.size() == 0) ? 6 : 6 + exp_q.size() + sumd;
      ok = (got_q.size() == exp_q.size()) ? 1 : 0;
      if (ok == 1)
         foreach (exp_q[i])
            if (got_q[i] != exp_q[i]) ok = 0;
      check({nm, ".lat"},   lat, elat);
      check({nm, ".stat"},  st, est);
      check({nm, ".disp"},  dsp, esum);
      check({nm, ".sels"},  ok, 1);
      check({nm, ".cass"},  int'(cass_cnt), int'(mpack()));
      check({nm, ".audit"}, int'(audit_total), exp_audit());
      check({nm, ".jam"},   int'(jam), 0);
   endtask

   initial begin
      int lat, st, dsp, sumd, bad;

      tbl[0] = '{cnt: {6'd2, 6'd1, 6'd1, 6'd3}, amt: 38, st: 0, dsp: 38,
                 lat: 12, ecnt: {6'd1, 6'd0, 6'd0, 6'd0}};
      tbl[1] = '{cnt: {6'd3, 6'd0, 6'd0, 6'd2}, amt: 63, st: 1, dsp: 0,
                 lat: 6, ecnt: {6'd3, 6'd0, 6'd0, 6'd2}};
      tbl[2] = '{cnt: {6'd1, 6'd1, 6'd1, 6'd1}, amt: 0, st: 0, dsp: 0,
                 lat: 6, ecnt: {6'd1, 6'd1, 6'd1, 6'd1}};
      tbl[3] = '{cnt: {6'd0, 6'd2, 6'd3, 6'd5}, amt: 37, st: 0, dsp: 37,
                 lat: 13, ecnt: {6'd0, 6'd0, 6'd0, 6'd3}};
      tbl[4] = '{cnt: {6'd3, 6'd0, 6'd0, 6'd0}, amt: 60, st: 0, dsp: 60,
                 lat: 9, ecnt: {6'd0, 6'd0, 6'd0, 6'd0}};
      tbl[5] = '{cnt: {6'd1, 6'd0, 6'd2, 6'd0}, amt: 25, st: 0, dsp: 25,
                 lat: 8, ecnt: {6'd0, 6'd0, 6'd1, 6'd0}};

      rst            = 1'b0;
      load_en        = 1'b0;
      load_sel       = 2'd0;
      load_cnt       = '0;
      bus.req_valid  = 1'b0;
      bus.req_amount = 6'd0;
      bus.feed_ack   = 1'b0;
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      maudit = 0;
      tick();
      tick();
      check_reset_vals("reset");
      rst = 1'b1;
      tick();
      check("reset.ready", int'(bus.req_ready), 1);

      foreach (tbl[i]) begin
         load_all(tbl[i].cnt);
         txn_check($sformatf("tbl%0d", i), tbl[i].amt, 0, 1'b0,
                   lat, st, dsp);
         check($sformatf("tbl%0d.lat_t", i), lat, tbl[i].lat);
         check($sformatf("tbl%0d.st_t", i), st, tbl[i].st);
         check($sformatf("tbl%0d.dsp_t", i), dsp, tbl[i].dsp);
         check($sformatf("tbl%0d.cnt_t", i), int'(cass_cnt),
               int'(tbl[i].ecnt));
         tick();
      end

      // Loads held high through PLAN/FEED/DONE must be ignored.
      load_all({6'd2, 6'd1, 6'd1, 6'd3});
      txn_check("gate", 38, 0, 1'b1, lat, st, dsp);
      check("gate.cnt_t", int'(cass_cnt), int'(24'h040000));
      tick();

      // Jam: first note acked, then transport stalls.
      load_all({6'd2, 6'd0, 6'd0, 6'd0});
      run_txn(40, 0, 1, 1'b0, lat, st, dsp, sumd);
      mcnt[3] = 1;
      maudit  = maudit + 20;
      check("jam.lat",  lat, 6 + TIMEOUT);
      check("jam.stat", st, 2);
      check("jam.disp", dsp, 20);
      check("jam.cass", int'(cass_cnt), int'(mpack()));
      tick();
      check("jam.flag",  int'(jam), 1);
      check("jam.ready", int'(bus.req_ready), 0);
      check("jam.audit", int'(audit_total), exp_audit());
      bad = 0;
      bus.req_valid  = 1'b1;
      bus.req_amount = 6'd5;
      for (int i = 0; i < 10; i++) begin
         if (bus.feed_valid || bus.done) bad = 1;
         tick();
      end
      bus.req_valid = 1'b0;
      check("jam.blocked", bad, 0);
      load_en  = 1'b1;
      load_sel = 2'd0;
      load_cnt = 6'd7;
      mcnt[0]  = 7;
      tick();
      load_en = 1'b0;
      check("jam.load", int'(cass_cnt), int'(mpack()));
      bus.feed_ack = 1'b1;
      tick();
      tick();
      tick();
      bus.feed_ack = 1'b0;
      check("stray_ack", int'(cass_cnt), int'(mpack()));

      // Reset after the second ack of a six-note withdrawal.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      maudit = 0;
      load_all({6'd2, 6'd1, 6'd1, 6'd3});
      bus.req_valid  = 1'b1;
      bus.req_amount = 6'd38;
      tick();
      bus.req_valid = 1'b0;
      bad = 1;
      for (int i = 0; i < 20; i++) begin
         if (bus.feed_valid) begin
            bad = 0;
            break;
         end
         tick();
      end
      check("rstmid.feed_seen", bad, 0);
      bus.feed_ack = 1'b1;
      tick();
      tick();
      check("rstmid.disp2", int'(bus.dispensed_amt), 30);
      bus.feed_ack = 1'b0;
      rst = 1'b0;
      tick();
      check_reset_vals("rstmid");
      rst = 1'b1;
      tick();
      check("rstmid.ready", int'(bus.req_ready), 1);

      for (int n = 0; n < 40; n++) begin
         logic [23:0] c;
         for (int i = 0; i < 4; i++)
            c[i*6 +: 6] = ($urandom_range(1, 0) == 1) ?
                          6'($urandom_range(7, 0)) : 6'(mcnt[i]);
         load_all(c);
         txn_check($sformatf("rnd%0d", n), int'($urandom_range(63, 0)), 3,
                   1'b0, lat, st, dsp);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/atm_cash_dispenser.md
# atm_cash_dispenser

Downstream stage of the ATM main controller. Accepts an approved withdrawal amount, plans a greedy note breakdown against four cassettes (20, 10, 5, 1), and feeds notes one at a time to the note-transport mechanism over a valid/ack handshake. Returns a one-cycle completion pulse with a status code and the amount actually dispensed.

## Interface
- `CNT_W`, default 6: width of each cassette note counter.
- `TIMEOUT`, default 16: maximum cycles to wait for `feed_ack` per note before declaring a jam.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: withdrawal request present.
- `req_amount` in 6: requested amount in units, 0–63.
- `req_ready` out 1: high only in IDLE with `jam`=0.
- `load_en` in 1: cassette load strobe.
- `load_sel` in 2: cassette index (3=20, 2=10, 1=5, 0=1).
- `load_cnt` in CNT_W: note count to write.
- `feed_valid` out 1: request one note.
- `feed_sel` out 2: cassette to draw from.
- `feed_ack` in 1: transport took one note.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: 0=OK, 1=NOFUNDS, 2=JAM; valid while `done`=1, held until the next `done`.
- `dispensed_amt` out 6: value actually fed in the last transaction.
- `jam` out 1: sticky fault flag.
- `cass_cnt` out 4×CNT_W: packed cassette counts, index 3 in the MSBs.
- `audit_total` out 16: cumulative dispensed value (see Configuration).

## Operation
- States: IDLE, PLAN, CHECK, FEED, DONE.
- **IDLE:** `req_valid && req_ready` latches `req_amount` into `remaining` and moves to PLAN with idx=3. `load_en` writes `cass_cnt[load_sel]` only in IDLE; it is ignored in all other states. If `req_valid` and `load_en` arrive in the same cycle, both take effect and the plan uses the old count.
- **PLAN:** one cycle per idx, 3 down to 0.
  - `need[idx] = min(remaining / denom[idx], cass_cnt[idx])`
  - `remaining -= need[idx] * denom[idx]`
  - Divide by constant denomination; all arithmetic is 6-bit and unsigned.
- **CHECK:**
  - If `remaining` != 0: go to DONE with NOFUNDS. No note is fed and counts are unchanged.
  - Else if all `need` = 0 (amount 0): go to DONE with OK.
  - Else: go to FEED.
- **FEED:**
  - Serves the highest idx with `need`>0.
  - `feed_valid`=1 with `feed_sel`=idx. `feed_sel` is stable while `feed_valid` is high.
  - On `feed_valid && feed_ack`: `need[idx]--`, `cass_cnt[idx]--`, `dispensed_amt += denom[idx]`, and the timeout counter clears.
  - `feed_valid` may stay high back-to-back into the next note.
  - When all `need` reach 0: go to DONE with OK.
  - If the timeout counter reaches `TIMEOUT` with no ack: go to DONE with JAM and set `jam`.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `jam` blocks new requests (`req_ready`=0) until `rst`. Loads remain accepted in IDLE.
- `dispensed_amt` clears at request acceptance.

## Timing
- Acceptance at cycle T. PLAN covers T+1..T+4, CHECK is T+5, and the first `feed_valid` is at T+6.
- NOFUNDS or zero-amount `done` is at T+6.
- OK after N notes with immediate acks: `done` at T+6+N.
- Reset values: FSM=IDLE, `cass_cnt`=0, `jam`=0, `done`=0, `status`=0, `dispensed_amt`=0, `feed_valid`=0, `feed_sel`=0, `audit_total`=0. `req_ready` is 1 from the first cycle after reset release.
- Reset in any state aborts within the same edge. `feed_valid` is low the next cycle and no partial counts are retained.
- `feed_ack` without `feed_valid` is ignored.

## Configuration
- `ATM_DISP_AUDIT_EN`
  - Defined: `audit_total` adds `denom[idx]` on every accepted note and saturates at 0xFFFF.
  - Undefined: `audit_total` is tied to 0 and no counter is built. The port list is identical in both builds.

## Structure
- Package `atm_disp_pkg` holds:
  - the state enum,
  - the status codes OK, NOFUNDS, JAM,
  - the denomination constant array {1, 5, 10, 20}.
- One sub-module, `disp_plan_step`: combinational `min(remaining/denom, cnt)` plus the remainder update, instantiated once and indexed by idx.

## Test plan
- **Greedy OK:** load counts 20:2, 10:1, 5:1, 1:3; request 38 with immediate acks -> six feeds with `feed_sel` 3,2,1,0,0,0; `status`=OK; `dispensed_amt`=38; counts become 1,0,0,0; `done` at T+12.
- **NOFUNDS:** counts 20:3, 10:0, 5:0, 1:2; request 63 -> no `feed_valid`; `done` at T+6 with `status`=1; counts unchanged.
- **Jam:** counts 20:2; request 40; ack the first note, then hold `feed_ack` low -> `done` `TIMEOUT` (16) cycles after the first ack with `status`=2, `dispensed_amt`=20, `jam`=1, `req_ready`=0; counts 20:1.
- **Zero request:** request 0 -> `done` at T+6, `status`=OK, no feed.
- **Reset mid-FEED:** request 38 and assert `rst` low after the second ack -> all outputs return to reset values next cycle and `cass_cnt` reads 0.
- **Load gating:** `load_en` during PLAN or FEED -> ignored. With `ATM_DISP_AUDIT_EN` defined, after the greedy-OK case `audit_total`=38.
